enc8_rr_queue: RTL and testbench
================================

Name: enc8_rr_queue

Overview:
- Sequential 8-to-3 request encoder, the inverse of the team's 3-to-8 one-hot decoder (DCD).
- Accumulates request pulses on 8 lines into a pending vector and emits one 3-bit index per accepted transfer over a valid/ready handshake.
- Selection is round-robin or fixed-priority, chosen by parameter.
- Sits between event sources and any consumer that drives DCD or MUX8 select lines.

Parameters:
RR_EN, 1, 1 = round-robin selection starting at the index after the last grant; 0 = fixed priority, lowest index wins.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_in  input  [0:7]  request pulses; bit 0 is leftmost and maps to index 0 (8'b10000000 -> idx 0).
clr  input  1  synchronous clear of all state.
out_ready  input  1  consumer accepts out_idx this cycle.
out_idx  output  [2:0]  encoded index of granted request.
out_valid  output  1  out_idx is valid.
pending  output  [0:7]  registered pending-request vector.
collide  output  1  sticky flag: a request arrived for an already-pending bit.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pending = 8'b0, out_valid = 0, out_idx = 3'd0, collide = 0, internal pointer ptr = 3'd0.
  - Deassertion takes effect at the next edge. Reset during an unaccepted transfer drops it; no recovery.
- Output stage is "free" when out_valid = 0, or out_valid = 1 and out_ready = 1.
- Each rising edge, clr = 0:
  - Selection uses the registered pending only, never the same-cycle req_in. Searched bits:
    - RR_EN = 1: ptr, ptr+1, ... wrapping mod 8; first set bit wins.
    - RR_EN = 0: 0..7; first set bit wins.
  - If the stage is free and pending != 0:
    - out_idx <= selected index g, out_valid <= 1.
    - pending bit g is cleared.
    - ptr <= g+1 mod 8 (wraps 7 -> 0).
  - If the stage is free and pending == 0: out_valid <= 0, out_idx holds.
  - If out_valid = 1 and out_ready = 0: out_idx and out_valid hold; no selection; pending bits are not cleared.
  - Pending update: pending <= (pending & ~grant_mask) | req_in.
    - A req_in bit equal to the bit being granted on the same edge stays set; it counts as a new request.
  - collide <= collide | (|(req_in & pending & ~grant_mask)).
    - A request on the index currently held in out_idx is not a collision, because that bit is already cleared from pending.
- clr = 1 (synchronous, overrides req_in and handshake on that edge):
  - pending, out_valid, collide and ptr go to 0. out_idx holds.
  - A transfer presented on the clr cycle counts as consumed only if out_ready = 1 on that cycle.
- Latency:
  - req_in asserted in cycle N sets pending after edge N.
  - out_valid rises after edge N+1 if the stage is free.
  - Best case is 2 cycles from request to index.
- Throughput: one index per cycle while out_ready = 1 and pending != 0. Back-to-back grants need no idle cycle.
- out_idx/out_valid change only at clock edges and never glitch combinationally on req_in.
- Round-trip property: DCD(out_idx) equals the one-hot of the granted bit.
- No counting: multiple pulses on the same bit before service collapse into one grant, and set collide.

Test Plan:
1. Reset and idle:
   - Stimulus: hold rst_n = 0, release; req_in = 0 for 5 cycles.
   - Required: out_valid = 0, pending = 8'b0, out_idx = 0, collide = 0 throughout.
2. Single request, latency and decode:
   - Stimulus: RR_EN = 1, out_ready = 1; req_in = 8'b00100000 for 1 cycle at cycle 3.
   - Required: pending = 8'b00100000 after edge 3; out_valid = 1 with out_idx = 2 after edge 4; DCD(out_idx) = 8'b00100000; out_valid = 0 after edge 5.
3. Round-robin order with wrap:
   - Stimulus: RR_EN = 1; first grant idx 5; then req_in = 8'b11000011 for 1 cycle; out_ready = 1.
   - Required: grants in order 6, 7, 0, 1 on consecutive cycles.
   - Same stimulus with RR_EN = 0: required grants 0, 1, 6, 7.
4. Backpressure hold:
   - Stimulus: pending = 8'b10010000; out_ready = 0 for 4 cycles, then 1.
   - Required: out_idx = 0 stable with out_valid = 1 while stalled; pending stays 8'b00010000; idx 3 follows on the cycle after acceptance.
5. Simultaneous events:
   - Stimulus A: req_in bit 3 pulsed on the same edge bit 3 is granted.
   - Required A: pending bit 3 remains set and a second idx 3 is emitted; collide = 0.
   - Stimulus B: pulse bit 3 again while it is pending.
   - Required B: collide = 1 and stays 1 until clr.
6. Clear and asynchronous reset mid-transfer:
   - Stimulus: out_valid = 1, out_ready = 0, pending = 8'hFF; assert clr with req_in = 8'h01.
   - Required: pending = 0, out_valid = 0, collide = 0 next cycle.
   - Repeat with rst_n pulsed low mid-cycle: all outputs reset immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/enc8_rr_queue.sv
`default_nettype none
// ============================================================================
// Module   : enc8_rr_queue
// Brief    : Sequential 8-to-3 request encoder. Request pulses on req_in are
//            collected into a pending vector. One 3-bit index is issued per
//            valid/ready transfer, using round-robin or fixed-priority
//            selection (chosen by RR_EN).
// Revision : 1.0 - initial release
// ============================================================================
module enc8_rr_queue #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [0:7] req_in,
    input  logic       clr,
    input  logic       out_ready,
    output logic [2:0] out_idx,
    output logic       out_valid,
    output logic [0:7] pending,
    output logic       collide
);

    // Registered state and next-state values
    logic [0:7] pending_q,   pending_d;
    logic [2:0] out_idx_q,   out_idx_d;
    logic       out_valid_q, out_valid_d;
    logic       collide_q,   collide_d;
    logic [2:0] ptr_q,       ptr_d;

    // Selection results (from registered pending only)
    logic [2:0] search_base;
    logic [2:0] cand;
    logic [2:0] sel_idx;
    logic       sel_found;
    logic       stage_free;
    logic       grant;
    logic [0:7] grant_mask;

    // Search pending from the start point; the first set bit wins
    always_comb begin
        search_base = RR_EN ? ptr_q : 3'd0;
        cand        = 3'd0;
        sel_idx     = 3'd0;
        sel_found   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cand = search_base + 3'(k);
            if (!sel_found && pending_q[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Decide whether a grant happens this edge and build its one-hot mask
    always_comb begin
        stage_free = !out_valid_q || out_ready;
        grant      = stage_free && sel_found;
        grant_mask = '0;
        for (int i = 0; i < 8; i++) begin
            grant_mask[i] = grant && (sel_idx == 3'(i));
        end
    end

    // Next-state: clear has priority, otherwise pending update and handshake
    always_comb begin
        pending_d   = pending_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        collide_d   = collide_q;
        ptr_d       = ptr_q;
        if (clr) begin
            // out_idx intentionally holds across a clear
            pending_d   = '0;
            out_valid_d = 1'b0;
            collide_d   = 1'b0;
            ptr_d       = 3'd0;
        end else begin
            // A new pulse on the bit being granted survives as a fresh request
            pending_d = (pending_q & ~grant_mask) | req_in;
            collide_d = collide_q | (|(req_in & pending_q & ~grant_mask));
            if (stage_free) begin
                if (sel_found) begin
                    out_idx_d   = sel_idx;
                    out_valid_d = 1'b1;
                    ptr_d       = sel_idx + 3'd1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            out_idx_q   <= 3'd0;
            out_valid_q <= 1'b0;
            collide_q   <= 1'b0;
            ptr_q       <= 3'd0;
        end else begin
            pending_q   <= pending_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            collide_q   <= collide_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;
    assign pending   = pending_q;
    assign collide   = collide_q;

endmodule
`default_nettype wire

// File: tb/tb_enc8_rr_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_enc8_rr_queue
// Brief    : Directed self-checking bench for enc8_rr_queue. A round-robin
//            instance and a fixed-priority instance share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enc8_rr_queue;

    logic       clk;
    logic       rst_n;
    logic [0:7] req_in;
    logic       clr;
    logic       out_ready;

    logic [2:0] rr_idx, fp_idx;
    logic       rr_valid, fp_valid;
    logic [0:7] rr_pend, fp_pend;
    logic       rr_col, fp_col;

    int tests;
    int fails;

    enc8_rr_queue #(.RR_EN(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .clr(clr), .out_ready(out_ready),
        .out_idx(rr_idx), .out_valid(rr_valid), .pending(rr_pend), .collide(rr_col)
    );

    enc8_rr_queue #(.RR_EN(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .clr(clr), .out_ready(out_ready),
        .out_idx(fp_idx), .out_valid(fp_valid), .pending(fp_pend), .collide(fp_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset and idle: all outputs stay at reset values
    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; req_in = 8'b0; out_ready = 1'b1;
        step(); step();
        tests++;
        if ({rr_valid, rr_idx, rr_pend, rr_col} !== {1'b0, 3'd0, 8'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_rr: got v=%b idx=%0d pend=%b col=%b, want all zero", rr_valid, rr_idx, rr_pend, rr_col);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            tests++;
            if ({rr_valid, rr_idx, rr_pend, rr_col, fp_valid, fp_idx, fp_pend, fp_col} !== 26'd0) begin
                fails++;
                $display("FAIL idle_cycle%0d: rr v=%b idx=%0d pend=%b col=%b fp v=%b idx=%0d pend=%b col=%b, want all zero",
                         c, rr_valid, rr_idx, rr_pend, rr_col, fp_valid, fp_idx, fp_pend, fp_col);
            end
        end
    endtask

    // Single request: 2-cycle latency and decode round trip
    task automatic test_single();
        logic [0:7] dcd;
        req_in = 8'b00100000;
        step();
        req_in = 8'b0;
        tests++;
        if ({rr_valid, rr_pend} !== {1'b0, 8'b00100000}) begin
            fails++;
            $display("FAIL single_pend: got v=%b pend=%b, want v=0 pend=00100000", rr_valid, rr_pend);
        end
        step();
        tests++;
        if ({rr_valid, rr_idx, rr_pend} !== {1'b1, 3'd2, 8'b0}) begin
            fails++;
            $display("FAIL single_grant: got v=%b idx=%0d pend=%b, want v=1 idx=2 pend=0", rr_valid, rr_idx, rr_pend);
        end
        dcd = 8'b0;
        dcd[rr_idx] = 1'b1;
        tests++;
        if (dcd !== 8'b00100000) begin
            fails++;
            $display("FAIL single_decode: got %b, want 00100000", dcd);
        end
        step();
        tests++;
        if (rr_valid !== 1'b0 || fp_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_drop: got rr_v=%b fp_v=%b, want 0", rr_valid, fp_valid);
        end
    endtask

    // Round-robin wrap order vs fixed priority order
    task automatic test_rr_order();
        logic [2:0] exp_rr [4];
        logic [2:0] exp_fp [4];
        exp_rr = '{3'd6, 3'd7, 3'd0, 3'd1};
        exp_fp = '{3'd0, 3'd1, 3'd6, 3'd7};
        req_in = 8'b00000100;
        step();
        req_in = 8'b0;
        step();
        tests++;
        if ({rr_valid, rr_idx, fp_valid, fp_idx} !== {1'b1, 3'd5, 1'b1, 3'd5}) begin
            fails++;
            $display("FAIL rr_first5: got rr v=%b idx=%0d fp v=%b idx=%0d, want both idx 5", rr_valid, rr_idx, fp_valid, fp_idx);
        end
        req_in = 8'b11000011;
        step();
        req_in = 8'b0;
        for (int g = 0; g < 4; g++) begin
            step();
            tests++;
            if ({rr_valid, rr_idx, fp_valid, fp_idx} !== {1'b1, exp_rr[g], 1'b1, exp_fp[g]}) begin
                fails++;
                $display("FAIL order_grant%0d: got rr v=%b idx=%0d fp v=%b idx=%0d, want rr %0d fp %0d",
                         g, rr_valid, rr_idx, fp_valid, fp_idx, exp_rr[g], exp_fp[g]);
            end
        end
        step();
        tests++;
        if (rr_valid !== 1'b0 || fp_valid !== 1'b0) begin
            fails++;
            $display("FAIL order_done: got rr_v=%b fp_v=%b, want 0", rr_valid, fp_valid);
        end
    endtask

    // Backpressure: held index stays stable and pending keeps the rest
    task automatic test_backpressure();
        clr = 1'b1;
        step();
        clr = 1'b0;
        out_ready = 1'b0;
        req_in = 8'b10010000;
        step();
        req_in = 8'b0;
        for (int s = 0; s < 4; s++) begin
            step();
            tests++;
            if ({rr_valid, rr_idx, rr_pend, fp_valid, fp_idx, fp_pend} !==
                {1'b1, 3'd0, 8'b00010000, 1'b1, 3'd0, 8'b00010000}) begin
                fails++;
                $display("FAIL stall%0d: got rr v=%b idx=%0d pend=%b fp v=%b idx=%0d pend=%b, want v=1 idx=0 pend=00010000",
                         s, rr_valid, rr_idx, rr_pend, fp_valid, fp_idx, fp_pend);
            end
        end
        out_ready = 1'b1;
        step();
        tests++;
        if ({rr_valid, rr_idx, rr_pend, fp_valid, fp_idx} !== {1'b1, 3'd3, 8'b0, 1'b1, 3'd3}) begin
            fails++;
            $display("FAIL after_accept: got rr v=%b idx=%0d pend=%b fp v=%b idx=%0d, want idx 3 pend 0",
                     rr_valid, rr_idx, rr_pend, fp_valid, fp_idx);
        end
        step();
    endtask

    // Same-edge re-request is a new request; pulse on pending bit is a collision
    task automatic test_simultaneous();
        req_in = 8'b00010000;
        step();
        step();
        req_in = 8'b0;
        tests++;
        if ({rr_valid, rr_idx, rr_pend, rr_col} !== {1'b1, 3'd3, 8'b00010000, 1'b0}) begin
            fails++;
            $display("FAIL same_edge_grant: got v=%b idx=%0d pend=%b col=%b, want v=1 idx=3 pend=00010000 col=0",
                     rr_valid, rr_idx, rr_pend, rr_col);
        end
        step();
        tests++;
        if ({rr_valid, rr_idx, rr_pend, rr_col, fp_col} !== {1'b1, 3'd3, 8'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL second_grant3: got v=%b idx=%0d pend=%b col=%b fp_col=%b, want v=1 idx=3 pend=0 col=0",
                     rr_valid, rr_idx, rr_pend, rr_col, fp_col);
        end
        step();
        out_ready = 1'b0;
        req_in = 8'b10010000;
        step();
        req_in = 8'b0;
        step();
        req_in = 8'b00010000;
        step();
        req_in = 8'b0;
        tests++;
        if ({rr_col, rr_pend, fp_col} !== {1'b1, 8'b00010000, 1'b1}) begin
            fails++;
            $display("FAIL collide_set: got rr_col=%b pend=%b fp_col=%b, want col=1 pend=00010000", rr_col, rr_pend, fp_col);
        end
        out_ready = 1'b1;
        step();
        step();
        tests++;
        if ({rr_col, rr_valid, fp_col} !== {1'b1, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL collide_sticky: got rr_col=%b v=%b fp_col=%b, want col=1 v=0", rr_col, rr_valid, fp_col);
        end
    endtask

    // Synchronous clear and asynchronous reset while a transfer is stalled
    task automatic test_clear_reset();
        out_ready = 1'b0;
        req_in = 8'hFF;
        step();
        step();
        req_in = 8'b0;
        tests++;
        if ({rr_valid, rr_idx, rr_pend, fp_valid, fp_idx, fp_pend} !== {1'b1, 3'd4, 8'hFF, 1'b1, 3'd0, 8'hFF}) begin
            fails++;
            $display("FAIL preclr: got rr v=%b idx=%0d pend=%b fp v=%b idx=%0d pend=%b, want rr idx4 fp idx0 pend FF",
                     rr_valid, rr_idx, rr_pend, fp_valid, fp_idx, fp_pend);
        end
        clr = 1'b1;
        req_in = 8'h01;
        step();
        clr = 1'b0;
        req_in = 8'b0;
        tests++;
        if ({rr_valid, rr_idx, rr_pend, rr_col, fp_valid, fp_idx, fp_pend, fp_col} !==
            {1'b0, 3'd4, 8'b0, 1'b0, 1'b0, 3'd0, 8'b0, 1'b0}) begin
            fails++;
            $display("FAIL clr: got rr v=%b idx=%0d pend=%b col=%b fp v=%b idx=%0d pend=%b col=%b, want cleared, idx held",
                     rr_valid, rr_idx, rr_pend, rr_col, fp_valid, fp_idx, fp_pend, fp_col);
        end
        req_in = 8'b01111111;
        step();
        step();
        req_in = 8'b0;
        tests++;
        if ({rr_valid, rr_idx, rr_col, rr_pend} !== {1'b1, 3'd1, 1'b1, 8'b01111111}) begin
            fails++;
            $display("FAIL prerst: got v=%b idx=%0d col=%b pend=%b, want v=1 idx=1 col=1 pend=01111111",
                     rr_valid, rr_idx, rr_col, rr_pend);
        end
        #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({rr_valid, rr_idx, rr_pend, rr_col, fp_valid, fp_idx, fp_pend, fp_col} !== 26'd0) begin
            fails++;
            $display("FAIL async_rst: got rr v=%b idx=%0d pend=%b col=%b fp v=%b idx=%0d pend=%b col=%b, want all zero",
                     rr_valid, rr_idx, rr_pend, rr_col, fp_valid, fp_idx, fp_pend, fp_col);
        end
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        tests++;
        if ({rr_valid, rr_idx, rr_pend, rr_col} !== {1'b0, 3'd0, 8'b0, 1'b0}) begin
            fails++;
            $display("FAIL post_rst: got v=%b idx=%0d pend=%b col=%b, want all zero", rr_valid, rr_idx, rr_pend, rr_col);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        clr = 1'b0;
        req_in = 8'b0;
        out_ready = 1'b1;
        #1;
        test_reset();
        test_single();
        test_rr_order();
        test_backpressure();
        test_simultaneous();
        test_clear_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
